div36x18_mc: RTL and testbench

- Multi-cycle signed divider: 36-bit dividend / 18-bit divisor -> 18-bit quotient + 18-bit remainder.
- Inverse companion of the single-cycle 18x18 DSP multiplier; used by the execute stage for DIV/MOD ops and to undo scaled products.
- Iterative radix-2 restoring core in fabric (no DSP); start/busy/done handshake; clock-enable gating matches the multiplier's `en`.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 25 ++
 rtl/div36x18_mc.sv | 139 +++++++++++++
 tb/tb_div36x18_mc.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the multi-cycle signed divider.
package div_pkg;

    localparam int DIV_WIDTH = 18;
    localparam int DIV_NW    = 2 * DIV_WIDTH;
    localparam int CNT_W     = $clog2(DIV_NW);

    // Largest quotient magnitudes that still fit in DIV_WIDTH signed bits
    localparam logic [DIV_NW-1:0] QMAX_POS = DIV_NW'((64'd1 << (DIV_WIDTH - 1)) - 64'd1);
    localparam logic [DIV_NW-1:0] QMAX_NEG = DIV_NW'(64'd1 << (DIV_WIDTH - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor magnitude, keep or restore.
module div_step #(
    parameter int WIDTH = 18
) (
    input  logic [WIDTH:0]   rem,
    input  logic             nbit,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH:0]   rem_next,
    output logic             qbit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // The incoming remainder is always below |D|, so its top bit is zero
    // and the shifted value fits in WIDTH+1 bits; one extra bit holds the borrow.
    always_comb begin
        shifted  = {rem[WIDTH-1:0], nbit};
        trial    = {1'b0, shifted} - {2'b00, dmag};
        qbit     = ~trial[WIDTH+1];
        rem_next = qbit ? trial[WIDTH:0] : shifted;
    end

endmodule

// File: rtl/div36x18_mc.sv
// Multi-cycle signed divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// quotient truncated toward zero, remainder takes the sign of the dividend.
module div36x18_mc
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               start,
    input  logic [2*WIDTH-1:0] N,
    input  logic [WIDTH-1:0]   D,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   R,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               dz
);

    localparam int NW = 2 * WIDTH;
    localparam int CW = $clog2(NW);

    div_state_t     state;
    logic [CW-1:0]  cnt;
    logic [NW-1:0]  nmag;
    logic [WIDTH-1:0] dmag;
    logic [WIDTH:0] rem;
    logic [NW-1:0]  qmag;
    logic           sign_q;
    logic           sign_r;
    logic           dz_pend;

    logic [NW-1:0]    nabs;
    logic [WIDTH-1:0] dabs;
    logic [WIDTH:0]   rem_next;
    logic             qbit;
    logic [NW-1:0]    qneg;
    logic [WIDTH-1:0] rmag;
    logic [WIDTH-1:0] rneg;
    logic             ovf_c;
    logic [WIDTH-1:0] q_c;
    logic [WIDTH-1:0] r_c;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .nbit     (nmag[NW-1]),
        .dmag     (dmag),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Operand magnitudes; the most negative dividend still fits as unsigned
    always_comb begin
        nabs = N[NW-1] ? -N : N;
        dabs = D[WIDTH-1] ? -D : D;
    end

    // Sign application and range check evaluated during FIX; negating zero
    // yields zero, so a negative zero result cannot appear
    always_comb begin
        qneg  = -qmag;
        rmag  = rem[WIDTH-1:0];
        rneg  = -rmag;
        ovf_c = dz_pend || (!sign_q && (qmag > QMAX_POS)) || (sign_q && (qmag > QMAX_NEG));
        q_c   = '0;
        r_c   = '0;
        if (!ovf_c) begin
            q_c = sign_q ? qneg[WIDTH-1:0] : qmag[WIDTH-1:0];
            r_c = sign_r ? rneg : rmag;
        end
    end

    // Control FSM and datapath registers; the done cycle is spent in IDLE
    // but a start seen while done is high is ignored, giving one op per 2W+3 clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            nmag    <= '0;
            dmag    <= '0;
            rem     <= '0;
            qmag    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_pend <= 1'b0;
            Q       <= '0;
            R       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            dz      <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !done) begin
                        nmag    <= nabs;
                        dmag    <= dabs;
                        sign_q  <= N[NW-1] ^ D[WIDTH-1];
                        sign_r  <= N[NW-1];
                        dz_pend <= (D == '0);
                        rem     <= '0;
                        qmag    <= '0;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    rem  <= rem_next;
                    qmag <= {qmag[NW-2:0], qbit};
                    nmag <= {nmag[NW-2:0], 1'b0};
                    if (cnt == CW'(NW - 1)) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    Q     <= q_c;
                    R     <= r_c;
                    ovf   <= ovf_c;
                    dz    <= dz_pend;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div36x18_mc.sv
// Self-checking bench for div36x18_mc against an integer-arithmetic model.
module tb_div36x18_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        start;
    logic [35:0] N;
    logic [17:0] D;
    logic [17:0] Q;
    logic [17:0] R;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        dz;

    int checks = 0;
    int failures = 0;

    div36x18_mc dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .N     (N),
        .D     (D),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, actual, actual, expected, expected);
        end
    endtask

    // Reference: truncating signed division with range check on the 18-bit result
    task automatic refModel(input longint n, input longint d,
                            output logic [17:0] eq, output logic [17:0] er,
                            output logic eovf, output logic edz);
        longint q;
        longint r;
        logic [63:0] tq;
        logic [63:0] tr;
        edz  = (d == 0);
        eovf = edz;
        eq   = '0;
        er   = '0;
        if (!edz) begin
            q = n / d;
            r = n % d;
            eovf = (q > 131071) || (q < -131072);
            if (!eovf) begin
                tq = q;
                tr = r;
                eq = tq[17:0];
                er = tr[17:0];
            end
        end
    endtask

    // Runs one division; the accepting edge counts as clock 1, done is
    // expected after clock 38 plus any disabled cycles inserted mid-run
    task automatic applyStimulus(input string name, input longint n, input longint d,
                                 input int stallAt, input int stallLen, input bit inject);
        logic [17:0] eq;
        logic [17:0] er;
        logic        eovf;
        logic        edz;
        logic [63:0] t;
        int          k;
        int          enabledClocks;
        refModel(n, d, eq, er, eovf, edz);
        @(negedge clk);
        t = n;
        N = t[35:0];
        t = d;
        D = t[17:0];
        en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        N = {$urandom, $urandom};
        D = 18'($urandom);
        checkOutput({name, ".busyAfterAccept"}, 64'(busy), 64'd1);
        k = 0;
        enabledClocks = 1;
        while (!done && k < 300) begin
            en = !(stallLen > 0 && k >= stallAt && k < stallAt + stallLen);
            start = inject && en && (k % 7 == 3);
            @(negedge clk);
            if (en) enabledClocks++;
            k++;
        end
        start = 1'b0;
        en = 1'b1;
        checkOutput({name, ".doneSeen"}, 64'(done), 64'd1);
        checkOutput({name, ".latencyEnabled"}, 64'(enabledClocks), 64'd38);
        checkOutput({name, ".latencyTotal"}, 64'(k + 1), 64'(38 + stallLen));
        checkOutput({name, ".busyOnDone"}, 64'(busy), 64'd0);
        checkOutput({name, ".Q"}, 64'(Q), 64'(eq));
        checkOutput({name, ".R"}, 64'(R), 64'(er));
        checkOutput({name, ".ovf"}, 64'(ovf), 64'(eovf));
        checkOutput({name, ".dz"}, 64'(dz), 64'(edz));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput({name, ".donePulse"}, 64'(done), 64'd0);
        checkOutput({name, ".startOnDoneIgnored"}, 64'(busy), 64'd0);
        checkOutput({name, ".Qheld"}, 64'(Q), 64'(eq));
    endtask

    function automatic longint sext36(input logic [35:0] v);
        logic [63:0] t;
        t = {{28{v[35]}}, v};
        return longint'(t);
    endfunction

    function automatic longint sext18(input logic [17:0] v);
        logic [63:0] t;
        t = {{46{v[17]}}, v};
        return longint'(t);
    endfunction

    // Directed cases, reset behaviour, then randomized operands
    initial begin
        longint dirN [8];
        longint dirD [8];
        logic [35:0] rn;
        logic [17:0] rd;
        bit sawDone;
        dirN = '{-699678, -7, 7, -7, 100, 131072, -131072, -(64'sd1 <<< 35)};
        dirD = '{567, 2, -2, -2, 0, 1, 1, -1};

        rst = 1'b1;
        en = 1'b1;
        start = 1'b0;
        N = '0;
        D = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.Q", 64'(Q), 64'd0);
        checkOutput("reset.R", 64'(R), 64'd0);
        checkOutput("reset.busy", 64'(busy), 64'd0);
        checkOutput("reset.done", 64'(done), 64'd0);
        checkOutput("reset.ovf", 64'(ovf), 64'd0);
        checkOutput("reset.dz", 64'(dz), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("dir%0d", i), dirN[i], dirD[i], 0, 0, 1'b0);
        end

        applyStimulus("stall", 1000, 7, 10, 5, 1'b1);

        @(negedge clk);
        N = 36'd5000;
        D = 18'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midReset.busy", 64'(busy), 64'd0);
        checkOutput("midReset.done", 64'(done), 64'd0);
        checkOutput("midReset.Q", 64'(Q), 64'd0);
        checkOutput("midReset.R", 64'(R), 64'd0);
        checkOutput("midReset.ovf", 64'(ovf), 64'd0);
        checkOutput("midReset.dz", 64'(dz), 64'd0);
        sawDone = 1'b0;
        repeat (45) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        checkOutput("midReset.noDone", 64'(sawDone), 64'd0);
        applyStimulus("afterReset", 1000, -7, 0, 0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            rn = {$urandom, $urandom};
            rd = 18'($urandom);
            applyStimulus($sformatf("rand%0d", i),
                          sext36(rn) >>> $urandom_range(0, 34),
                          sext18(rd) >>> $urandom_range(0, 17),
                          int'($urandom_range(0, 30)), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
